mux_rr_reg: RTL and testbench

- Parametrised, registered N-to-1 data multiplexer with per-input valid/ready handshake. Next generation of the team's 16-bit 4:1 mux.
- Two runtime modes:
  - direct select: a `sel` input chooses the channel, as the existing mux does.
  - round-robin arbitration: the block picks among inputs that are valid.
- Sits between multiple datapath producers and a single consumer. Its output is a one-entry register that holds its value under backpressure.

---
 rtl/mux_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/mux_rr_reg.sv | 90 +++++++++
 tb/tb_mux_rr_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the multiplexer family: mode encoding and a reusable
// rotate-and-find-first search for round-robin arbiters.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Largest channel count the shared search supports.
    localparam int MAX_N = 32;
    localparam int IDX_W = $clog2(MAX_N);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0], searching from ptr+1 upward and wrapping at n.
    // ptr must be below n, so ptr+k stays below 2n and one subtraction replaces a modulo.
    function automatic rr_pick_t rr_find_first(input logic [MAX_N-1:0] req,
                                               input int ptr,
                                               input int n);
        rr_pick_t pick;
        int       j;
        pick = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (k <= n && !pick.valid && req[j]) begin
                pick.valid = 1'b1;
                pick.idx   = IDX_W'(j);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first requester after ptr,
// wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [MAX_N-1:0] req_ext;
    rr_pick_t         pick;

    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_find_first(req_ext, 32'(ptr), N);
    end

    assign gnt_valid = pick.valid;
    assign gnt_idx   = pick.idx[SEL_W-1:0];

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N:1 multiplexer with per-channel valid/ready, selectable between a
// direct channel select and round-robin arbitration over valid inputs.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic             rr_gnt_valid;
    logic [SEL_W-1:0] rr_gnt_idx;
    logic             sel_hit;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] load_word;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // Compare sel against each real channel so an out-of-range sel simply never hits.
    always_comb begin
        sel_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) sel_hit = in_valid[i];
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant_valid = rr_gnt_valid;
            grant       = rr_gnt_idx;
        end else begin
            grant_valid = sel_hit;
            grant       = sel;
        end
    end

    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && grant_valid && !rst;

    always_comb begin
        in_ready  = '0;
        load_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SEL_W'(i)) begin
                in_ready[i] = xfer;
                load_word   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= load_word;
            out_src   <= grant;
            if (mode == MODE_RR) rr_ptr <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed self-checking bench for mux_rr_reg (WIDTH=16, N=4).
module tb_mux_rr_reg;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    int checks   = 0;
    int failures = 0;

    mux_rr_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] d);
        in_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                             input logic [SEL_W-1:0] s);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        logic [SEL_W-1:0] rr_seq [5];
        logic [SEL_W-1:0] alt_seq [4];
        rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        alt_seq = '{2'd1, 2'd3, 2'd1, 2'd3};

        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;

        // Reset then idle.
        tick();
        in_valid = 4'b1111;
        #1;
        check("rst_in_ready_held", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        tick();
        check_out("reset", 1'b0, 16'h0, 2'd0);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;

        // Direct select of channel 2.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
        set_ch(0, 16'h1111); set_ch(1, 16'h2222); set_ch(2, 16'hC0DE); set_ch(3, 16'h4444);
        #1;
        check("sel2_in_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("sel2", 1'b1, 16'hC0DE, 2'd2);

        // Selected channel not valid: no transfer, held word drains.
        sel = 2'd1; in_valid = 4'b1101;
        #1;
        check("sel1_invalid_in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("sel1_invalid", 1'b0, 16'hC0DE, 2'd2);

        // Round robin, all valid; pointer still at reset value 3.
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_ch(i, 16'(16'hA000 + i));
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_all_%0d", k), 32'(out_src), 32'(rr_seq[k]));
            check($sformatf("rr_all_data_%0d", k), 32'(out_data), 32'(16'hA000 + rr_seq[k]));
        end

        // Round robin over 4'b1010, pointer now at 0.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_alt_%0d", k), 32'(out_src), 32'(alt_seq[k]));
        end

        // Backpressure: hold 16'h1234 for 5 cycles.
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_ch(0, 16'h1234);
        tick();
        check_out("bp_load", 1'b1, 16'h1234, 2'd0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0) ? 4'b1111 : 4'b0101;
            set_ch(0, 16'(16'h9000 + k));
            sel = SEL_W'(k);
            #1;
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
            tick();
            check($sformatf("bp_hold_data_%0d", k), 32'(out_data), 32'h1234);
            check($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'h1);
        end
        sel = 2'd0; in_valid = 4'b0001; set_ch(0, 16'h5678); out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'h1);
        tick();
        check_out("bp_release", 1'b1, 16'h5678, 2'd0);

        // Mode switch: RR grants 1, SEL grants 3, RR resumes searching from 2.
        mode = 1'b1; in_valid = 4'b0010;
        tick();
        check("ms_rr1_src", 32'(out_src), 32'h1);
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1111;
        #1;
        check("ms_sel3_in_ready", 32'(in_ready), 32'h8);
        tick();
        check("ms_sel3_src", 32'(out_src), 32'h3);
        mode = 1'b1;
        #1;
        check("ms_rr_resume_in_ready", 32'(in_ready), 32'h4);
        tick();
        check("ms_rr_resume_src", 32'(out_src), 32'h2);

        // Reset mid-operation drops the held word.
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_ch(0, 16'hBEEF);
        tick();
        check_out("pre_rst", 1'b1, 16'hBEEF, 2'd0);
        out_ready = 1'b0; rst = 1'b1;
        tick();
        check_out("mid_rst", 1'b0, 16'h0, 2'd0);
        rst = 1'b0; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_ch(i, 16'(16'hB000 + i));
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        check_out("post_rst", 1'b1, 16'hB000, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
